// File: rtl/filter2d_pkg.sv
// Shared types and constants for the 2D filter sequencer and its SRAM arbiter.
package filter2d_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;
    localparam int KTAPS  = 9;
    localparam int IDX_W  = 4;

    // Default kernel: sharpening mask, -1 around a centre weight of 16.
    localparam logic [DATA_W-1:0] KDEF_EDGE   = 8'hFF;
    localparam logic [DATA_W-1:0] KDEF_CENTER = 8'h10;
    localparam int                KCENTER     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KLOAD,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic logic [DATA_W-1:0] default_tap(input int idx);
        return (idx == KCENTER) ? KDEF_CENTER : KDEF_EDGE;
    endfunction

endpackage

// File: rtl/filter2d_sram_mux.sv
// Owner-select between host and engine on the single-port image SRAM,
// plus the registered read-valid for host reads.
module filter2d_sram_mux
    import filter2d_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              eng_own,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              eng_cs,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_din,
    output logic [DATA_W-1:0] eng_dout,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    always_comb begin
        host_gnt = 1'b0;
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = host_addr;
        mem_din  = host_wdata;
        if (eng_own) begin
            mem_cs   = eng_cs;
            mem_we   = eng_we;
            mem_addr = eng_addr;
            mem_din  = eng_din;
        end else begin
            host_gnt = host_req;
            mem_cs   = host_req;
            mem_we   = host_we & host_req;
        end
    end

    assign eng_dout   = mem_dout;
    assign host_rdata = mem_dout;

    // SRAM has one cycle of read latency, so valid trails the granted read by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= host_gnt & ~host_we;
        end
    end

endmodule

// File: rtl/filter2d_ctrl.sv
// Frame sequencer for the 2D filter engine: streams the kernel shadow, starts the
// engine, guards the run with a watchdog and arbitrates the shared image SRAM.
module filter2d_ctrl
    import filter2d_pkg::*;
#(
    parameter int          WIDTH   = 256,
    parameter int          TO_W    = 20,
    parameter int unsigned TIMEOUT = 20'hFFFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        frame_cnt,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              eng_start,
    input  logic              eng_finish,
    input  logic              eng_cs,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_din,
    output logic [DATA_W-1:0] eng_dout,
    output logic              h_write,
    output logic [IDX_W-1:0]  h_idx,
    output logic [DATA_W-1:0] h_data,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    if (64'(TIMEOUT) <= 64'(WIDTH) * 64'(WIDTH) * 64'd12) begin : g_timeout_guard
        $error("filter2d_ctrl: TIMEOUT too small for WIDTH");
    end

    // Watchdog holds cycles elapsed since START, so a timeout lands DONE exactly TIMEOUT cycles after it.
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    state_t            state;
    logic [TO_W-1:0]   wd;
    logic [DATA_W-1:0] shadow [KTAPS];
    logic              eng_own;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < KTAPS; i++) begin
                shadow[i] <= default_tap(i);
            end
        end else if (state == ST_IDLE && cfg_we && cfg_idx < IDX_W'(KTAPS)) begin
            shadow[cfg_idx] <= cfg_data;
        end
    end

    // Outputs are set on the transition into each state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            frame_cnt <= '0;
            eng_start <= 1'b0;
            h_write   <= 1'b0;
            h_idx     <= '0;
            h_data    <= '0;
            wd        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state   <= ST_KLOAD;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        h_write <= 1'b1;
                        h_idx   <= '0;
                        h_data  <= shadow[0];
                    end
                end
                ST_KLOAD: begin
                    if (h_idx == IDX_W'(KTAPS - 1)) begin
                        state     <= ST_START;
                        h_write   <= 1'b0;
                        eng_start <= 1'b1;
                    end else begin
                        h_idx  <= h_idx + 1'b1;
                        h_data <= shadow[h_idx + 1'b1];
                    end
                end
                ST_START: begin
                    state     <= ST_RUN;
                    eng_start <= 1'b0;
                    wd        <= TO_W'(1);
                end
                ST_RUN: begin
                    if (eng_finish) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (wd == WD_LAST) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    if (!err) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign eng_own = (state == ST_START) || (state == ST_RUN);

    filter2d_sram_mux u_sram_mux (
        .clk         (clk),
        .reset_n     (reset_n),
        .eng_own     (eng_own),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .eng_cs      (eng_cs),
        .eng_we      (eng_we),
        .eng_addr    (eng_addr),
        .eng_din     (eng_din),
        .eng_dout    (eng_dout),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout)
    );

endmodule

// File: tb/tb_filter2d_ctrl.sv
// Randomized self-checking bench for filter2d_ctrl against a frame-timeline reference model.
module tb_filter2d_ctrl;

    localparam int TB_TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        busy, done, err;
    logic [7:0]  frame_cnt;
    logic        cfg_we;
    logic [3:0]  cfg_idx;
    logic [7:0]  cfg_data;
    logic        host_req, host_we;
    logic [16:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_gnt, host_rvalid;
    logic [7:0]  host_rdata;
    logic        eng_start, eng_finish;
    logic        eng_cs, eng_we;
    logic [16:0] eng_addr;
    logic [7:0]  eng_din, eng_dout;
    logic        h_write;
    logic [3:0]  h_idx;
    logic [7:0]  h_data;
    logic        mem_cs, mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = 8'h00;

    int tests = 0;
    int fails = 0;

    logic [7:0]  sram [0:(1<<17)-1];
    logic [7:0]  exp_mem [logic [16:0]];
    logic [16:0] waddrs [$];
    logic [7:0]  kmodel [9];
    int          exp_frames;
    bit          exp_err;
    bit          exp_rvalid;
    logic [7:0]  exp_rdata;
    bit          gnt_exp;

    filter2d_ctrl #(.WIDTH(2), .TO_W(20), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .busy(busy), .done(done), .err(err),
        .frame_cnt(frame_cnt), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .eng_start(eng_start), .eng_finish(eng_finish), .eng_cs(eng_cs), .eng_we(eng_we),
        .eng_addr(eng_addr), .eng_din(eng_din), .eng_dout(eng_dout),
        .h_write(h_write), .h_idx(h_idx), .h_data(h_data),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) sram[mem_addr] <= mem_din;
            else        mem_dout <= sram[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 9; i++) kmodel[i] = (i == 4) ? 8'h10 : 8'hFF;
        exp_frames = 0;
        exp_err    = 1'b0;
        exp_rvalid = 1'b0;
    endtask

    // Engine traffic stays in the upper half so it never disturbs host data.
    task automatic drive_engine();
        eng_cs   = 1'($urandom);
        eng_we   = 1'($urandom);
        eng_addr = {1'b1, 16'($urandom)};
        eng_din  = 8'($urandom);
    endtask

    task automatic sample(input bit host_owns);
        @(negedge clk);
        checkOutput("host_rvalid", host_rvalid, exp_rvalid);
        if (exp_rvalid) checkOutput("host_rdata", host_rdata, exp_rdata);
        checkOutput("eng_dout", eng_dout, mem_dout);
        gnt_exp = host_owns && host_req;
        checkOutput("host_gnt", host_gnt, gnt_exp);
        if (host_owns) begin
            checkOutput("mem_cs_host", mem_cs, host_req);
            checkOutput("mem_we_host", mem_we, host_we && host_req);
            checkOutput("mem_addr_host", mem_addr, host_addr);
            checkOutput("mem_din_host", mem_din, host_wdata);
        end else begin
            checkOutput("mem_cs_eng", mem_cs, eng_cs);
            checkOutput("mem_we_eng", mem_we, eng_we);
            checkOutput("mem_addr_eng", mem_addr, eng_addr);
            checkOutput("mem_din_eng", mem_din, eng_din);
        end
    endtask

    task automatic advance();
        if (gnt_exp && host_we) begin
            exp_mem[host_addr] = host_wdata;
            waddrs.push_back(host_addr);
        end
        exp_rvalid = gnt_exp && !host_we;
        if (exp_rvalid) exp_rdata = exp_mem[host_addr];
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks();
        checkOutput("busy_idle", busy, 1'b0);
        checkOutput("done_idle", done, 1'b0);
        checkOutput("err_idle", err, exp_err);
        checkOutput("frame_cnt", frame_cnt, 32'(exp_frames));
        checkOutput("eng_start_idle", eng_start, 1'b0);
        checkOutput("h_write_idle", h_write, 1'b0);
    endtask

    // Random idle traffic: host writes/reads and kernel shadow writes (some out of range).
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            int op;
            op = int'($urandom_range(0, 3));
            drive_engine();
            host_req = 1'b0; host_we = 1'b0; cfg_we = 1'b0;
            if (op == 0) begin
                host_req = 1'b1; host_we = 1'b1;
                host_addr = 17'($urandom_range(0, 1023));
                host_wdata = 8'($urandom);
            end else if (op == 1 && waddrs.size() > 0) begin
                host_req = 1'b1;
                host_addr = waddrs[$urandom_range(0, waddrs.size() - 1)];
            end else if (op == 2) begin
                cfg_we = 1'b1;
                cfg_idx = 4'($urandom);
                cfg_data = 8'($urandom);
            end
            sample(1'b1);
            idle_checks();
            if (cfg_we && cfg_idx < 4'd9) kmodel[cfg_idx] = cfg_data;
            advance();
            host_req = 1'b0; cfg_we = 1'b0;
        end
    endtask

    task automatic host_op(input bit we, input logic [16:0] addr, input logic [7:0] data);
        drive_engine();
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = data; cfg_we = 1'b0;
        sample(1'b1);
        idle_checks();
        advance();
        host_req = 1'b0;
    endtask

    // One frame from the accepting IDLE cycle through DONE; finish_at=0 means the engine never finishes.
    task automatic do_frame(input int finish_at, input bit hold, input logic [16:0] haddr, input int abort_at);
        bit timed_out;
        timed_out = 1'b0;
        drive_engine();
        run = 1'b1; cfg_we = 1'b0; eng_finish = 1'b0;
        host_req = hold; host_we = 1'b0; host_addr = haddr;
        sample(1'b1);
        idle_checks();
        advance();
        run = 1'b0;
        exp_err = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive_engine();
            sample(1'b1);
            checkOutput("h_write", h_write, 1'b1);
            checkOutput("h_idx", h_idx, 32'(k));
            checkOutput("h_data", h_data, kmodel[k]);
            checkOutput("busy_kload", busy, 1'b1);
            checkOutput("err_kload", err, 1'b0);
            checkOutput("eng_start_kload", eng_start, 1'b0);
            advance();
        end
        drive_engine();
        sample(1'b0);
        checkOutput("eng_start", eng_start, 1'b1);
        checkOutput("h_write_start", h_write, 1'b0);
        checkOutput("busy_start", busy, 1'b1);
        advance();
        for (int j = 1; j < TB_TIMEOUT; j++) begin
            drive_engine();
            eng_finish = (j == finish_at);
            run = 1'($urandom);
            cfg_we = (j == 2);
            cfg_idx = 4'd4;
            cfg_data = 8'h20;
            if (j == abort_at) begin
                reset_n = 1'b0;
                #2;
                checkOutput("busy_abort", busy, 1'b0);
                checkOutput("done_abort", done, 1'b0);
                checkOutput("eng_start_abort", eng_start, 1'b0);
                checkOutput("frame_cnt_abort", frame_cnt, 32'd0);
                checkOutput("rvalid_abort", host_rvalid, 1'b0);
                run = 1'b0; cfg_we = 1'b0; eng_finish = 1'b0; host_req = 1'b0;
                @(posedge clk);
                #1;
                reset_n = 1'b1;
                reset_model();
                return;
            end
            sample(1'b0);
            checkOutput("eng_start_run", eng_start, 1'b0);
            checkOutput("busy_run", busy, 1'b1);
            checkOutput("done_run", done, 1'b0);
            advance();
            if (j == finish_at) break;
            if (j == TB_TIMEOUT - 1) timed_out = 1'b1;
        end
        eng_finish = 1'b0; cfg_we = 1'b0;
        run = 1'b1;
        drive_engine();
        sample(1'b1);
        checkOutput("done", done, 1'b1);
        checkOutput("busy_done", busy, 1'b1);
        checkOutput("err_done", err, timed_out);
        advance();
        run = 1'b0; host_req = 1'b0;
        if (!timed_out) exp_frames = (exp_frames + 1) % 256;
        exp_err = timed_out;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        reset_n = 1'b0; run = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        eng_finish = 1'b0; eng_cs = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_din = '0;
        reset_model();
        #3;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_eng_start", eng_start, 1'b0);
        checkOutput("rst_h_write", h_write, 1'b0);
        checkOutput("rst_host_gnt", host_gnt, 1'b0);
        checkOutput("rst_host_rvalid", host_rvalid, 1'b0);
        checkOutput("rst_mem_cs", mem_cs, 1'b0);
        checkOutput("rst_mem_we", mem_we, 1'b0);
        checkOutput("rst_frame_cnt", frame_cnt, 32'd0);
        checkOutput("rst_h_idx", h_idx, 32'd0);
        checkOutput("rst_h_data", h_data, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        applyStimulus(2);
        host_op(1'b1, 17'h00123, 8'h5A);
        host_op(1'b0, 17'h00123, 8'h00);
        applyStimulus(1);
        checkOutput("directed_5a", exp_rdata, 8'h5A);

        do_frame(3, 1'b0, 17'h0, 0);
        do_frame(6, 1'b1, 17'h00123, 0);

        drive_engine();
        cfg_we = 1'b1; cfg_idx = 4'd4; cfg_data = 8'h08;
        sample(1'b1);
        idle_checks();
        kmodel[4] = 8'h08;
        advance();
        cfg_we = 1'b1; cfg_idx = 4'd12; cfg_data = 8'h55;
        sample(1'b1);
        idle_checks();
        advance();
        cfg_we = 1'b0;
        do_frame(2, 1'b0, 17'h0, 0);

        applyStimulus(8);
        do_frame(0, 1'b0, 17'h0, 0);
        applyStimulus(2);
        do_frame(2, 1'b1, waddrs[0], 0);

        for (int f = 0; f < 256; f++) begin
            bit h;
            h = 1'($urandom);
            do_frame(int'($urandom_range(1, 5)), h, waddrs[$urandom_range(0, waddrs.size() - 1)], 0);
        end
        applyStimulus(6);

        do_frame(0, 1'b0, 17'h0, 5);
        applyStimulus(4);
        do_frame(2, 1'b0, 17'h0, 0);
        applyStimulus(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/filter2d_ctrl.md
Name: filter2d_ctrl

Overview:
- Sequencer and SRAM arbiter that sits in front of the 2D filter engine and the shared single-port image SRAM (17-bit address, 8-bit data, 1-cycle read latency).
- Holds a shadow copy of the 3x3 kernel and streams it into the engine's kernel port, then pulses the engine start and waits for its finish.
- Gives the engine exclusive SRAM ownership during a run. The host can load source pixels and read back results at all other times.

Parameters:
- WIDTH, 256, image side in pixels; must match the engine.
- TO_W, 20, watchdog counter width.
- TIMEOUT, 20'hFFFFF, maximum cycles in RUN before abort; must exceed WIDTH*WIDTH*12.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- run  in  1  one-cycle request to filter one frame
- busy  out  1  high from accepted run until DONE exits
- done  out  1  one-cycle pulse at end of frame
- err  out  1  sticky timeout flag; cleared by the next accepted run
- frame_cnt  out  8  successful frames, wraps 255->0
- cfg_we  in  1  kernel shadow write
- cfg_idx  in  4  tap index 0..8
- cfg_data  in  8  signed coefficient
- host_req  in  1  host SRAM access request
- host_we  in  1  1=write, 0=read
- host_addr  in  17  host address
- host_wdata  in  8  host write data
- host_gnt  out  1  access accepted this cycle
- host_rvalid  out  1  host_rdata valid; one cycle after a granted read
- host_rdata  out  8  read data
- eng_start  out  1  to engine start
- eng_finish  in  1  from engine finish
- eng_cs, eng_we  in  1 each  engine SRAM strobes
- eng_addr  in  17  engine address
- eng_din  in  8  engine write data
- eng_dout  out  8  SRAM read data to engine
- h_write  out  1  engine kernel write strobe
- h_idx  out  4  engine kernel index
- h_data  out  8  engine kernel data
- mem_cs, mem_we  out  1 each  SRAM strobes
- mem_addr  out  17  SRAM address
- mem_din  out  8  SRAM write data
- mem_dout  in  8  SRAM read data

Behaviour:
- Reset values: busy, done, err, eng_start, h_write, host_gnt, host_rvalid, mem_cs and mem_we are 0. frame_cnt, h_idx, h_data and mem_addr are 0. The state is IDLE.
- Reset loads the kernel shadow with -1 on taps 0-3 and 5-8, and 16 (8'h10) on tap 4. Reset mid-run aborts immediately with no done pulse.
- FSM states: IDLE, KLOAD, START, RUN, DONE.
  - IDLE: run=1 moves to KLOAD and clears err. run is ignored in every other state.
  - KLOAD: 9 cycles. h_write=1, h_idx=k, h_data=shadow[k] for k=0..8. The next state is START.
  - START: eng_start=1 for exactly 1 cycle. Clears the watchdog. The next state is RUN.
  - RUN: wait for eng_finish, then go to DONE. If the watchdog reaches TIMEOUT, set err=1 and go to DONE.
  - DONE: done=1 for 1 cycle. frame_cnt increments only if err=0. The next state is IDLE.
- busy=1 in KLOAD, START, RUN and DONE.
- cfg_we is honoured only in IDLE and ignored otherwise, so the kernel is frozen per frame. A cfg_idx greater than 8 is ignored.
- SRAM ownership:
  - In START and RUN the engine owns the SRAM: the mem_* outputs equal eng_* combinationally, and host_gnt=0.
  - In IDLE, KLOAD and DONE the host owns it: host_gnt=host_req, mem_cs=host_req, mem_we=host_we&host_req, mem_addr=host_addr, mem_din=host_wdata.
  - While the host owns the SRAM, eng_cs is ignored.
- An ungranted host request performs no access. The host holds its request until granted.
- eng_dout=mem_dout at all times.
- Read return: host_rvalid is registered; it goes high the cycle after a granted read. host_rdata=mem_dout.
  - A read granted in DONE still returns its rvalid in the following IDLE cycle.
  - A host read granted on the last KLOAD cycle returns its rvalid during START. This is legal: the engine issues no reads in START.
- A run request arriving in the same cycle as a host request in IDLE is accepted, and the host request is also granted that cycle.

Decomposition:
- Package filter2d_pkg holds:
  - the state enum;
  - ADDR_W=17, DATA_W=8, KTAPS=9;
  - the default kernel constants.
- One sub-module, filter2d_sram_mux: the combinational owner-select mux between host and engine, plus the registered host_rvalid.

Test Plan:
- Reset, then run with no cfg writes. Expect:
  - 9 h_write cycles with h_data = FF,FF,FF,FF,10,FF,FF,FF,FF;
  - eng_start high for one cycle on the next cycle;
  - busy=1 until done.
- Host writes 0x5A to address 0x00123, then reads it. Expect host_gnt=1 on both, then host_rvalid=1 the cycle after the read with host_rdata=0x5A.
- Hold host_req during RUN. Expect:
  - host_gnt=0 and mem_addr tracking eng_addr throughout;
  - host_gnt=1 in the DONE cycle.
- Write cfg 4=0x20 during RUN, then write cfg 4=0x08 in IDLE, then run. Expect the second KLOAD to send h_idx=4 with h_data=0x08.
- Model the engine with eng_finish never asserting and set TIMEOUT=100. Expect done at 100 cycles after START, err=1, frame_cnt unchanged, and err cleared on the next run.
- Run 256 back-to-back frames. Expect frame_cnt to wrap to 0. Assert reset_n low mid-RUN and expect busy=0 immediately with no done pulse.
